riv_async_fifo_wr_ctrl: RTL and testbench

Write-side controller of the riv async FIFO, in the write clock domain directly upstream of the dual-port FIFO memory. It accepts a valid/ready write stream and drives the memory's write enable and write address. It publishes a Gray-coded write pointer to the read domain and synchronises the read domain's Gray pointer back. From that it derives full, almost-full and an occupancy level.

---
 rtl/riv_async_fifo_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_riv_async_fifo_wr_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/riv_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : riv_async_fifo_wr_ctrl
//  Description : Write-side controller of the riv async FIFO. Accepts a
//                valid/ready write stream, drives the memory write port,
//                publishes a Gray write pointer and derives full,
//                almost-full and occupancy from the synchronised read pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module riv_async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wvalid,
  output logic                  wready,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  // Pointer state
  logic [ADDR_WIDTH:0] wbin_q;
  logic [ADDR_WIDTH:0] wbin_d;
  logic [ADDR_WIDTH:0] wgray_q;
  logic [ADDR_WIDTH:0] wgray_d;

  // Read-pointer synchroniser chain; sync_q[0] is the first capture flop
  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] rq;
  logic [ADDR_WIDTH:0] rbin;

  // Status
  logic                wready_q;
  logic                wfull_q;
  logic                walmost_full_q;
  logic [ADDR_WIDTH:0] wlevel_q;
  logic [ADDR_WIDTH:0] full_gray;
  logic [ADDR_WIDTH:0] level_d;
  logic                full_d;
  logic                afull_d;

  // A write is accepted only while the registered ready is high
  assign wen    = wvalid & wready_q;
  assign wbin_d = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
  assign wgray_d = wbin_d ^ (wbin_d >> 1);

  // Synchroniser: the first stage samples rptr_gray directly with no logic
  // in front, so the Gray property keeps metastability to a single bit.
  generate
    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
      if (s == 0) begin : g_first
        // First capture flop of the asynchronous read pointer
        always_ff @(posedge wclk or posedge wrst) begin
          if (wrst) sync_q[0] <= '0;
          else      sync_q[0] <= rptr_gray;
        end
      end else begin : g_rest
        // Further resolution stages
        always_ff @(posedge wclk or posedge wrst) begin
          if (wrst) sync_q[s] <= '0;
          else      sync_q[s] <= sync_q[s-1];
        end
      end
    end
  endgenerate

  assign rq = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  generate
    for (genvar i = 0; i < PTR_W; i++) begin : g_gray2bin
      assign rbin[i] = ^(rq >> i);
    end
  endgenerate

  // Full when the next write pointer equals the read pointer with the two
  // top Gray bits inverted (one full lap ahead).
  assign full_gray = {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]};
  assign full_d    = (wgray_d == full_gray);
  assign level_d   = wbin_d - rbin;
  assign afull_d   = (level_d >= AFULL_LVL);

  // Write pointer registers, binary for addressing and Gray for export
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
    end
  end

  // Status registers; ready is held low for the first cycle after reset
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wready_q       <= 1'b0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
    end else begin
      wready_q       <= ~full_d;
      wfull_q        <= full_d;
      walmost_full_q <= afull_d;
      wlevel_q       <= level_d;
    end
  end

  assign wready       = wready_q;
  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;

endmodule
`default_nettype wire

// File: tb/tb_riv_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riv_async_fifo_wr_ctrl
//  Description : Self-checking bench for riv_async_fifo_wr_ctrl with a
//                count-based reference model of the write-side FIFO view.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riv_async_fifo_wr_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          wvalid;
  logic          wready;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: total writes accepted, total reads performed by
  // the (virtual) read side, and the read count as the write side sees it.
  int m_writes = 0;
  int m_reads  = 0;
  int rd_d1 = 0, rd_d2 = 0;
  int m_level = 0;
  bit m_ready = 0, m_full = 0, m_afull = 0;

  function automatic logic [2:0] gray3(int b);
    logic [2:0] x;
    x = 3'(b);
    return x ^ (x >> 1);
  endfunction

  assign rptr_gray = gray3(m_reads);

  riv_async_fifo_wr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (2),
    .AFULL_THRESH(3)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .wvalid      (wvalid),
    .wready      (wready),
    .wen         (wen),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .rptr_gray   (rptr_gray),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel)
  );

  always #5 wclk = ~wclk;

  // Reference model: the read count becomes visible two edges after it is
  // driven and lands in the status outputs on the following edge.
  always @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      m_writes = 0; rd_d1 = 0; rd_d2 = 0; m_level = 0;
      m_ready = 0; m_full = 0; m_afull = 0;
    end else begin
      if (wvalid && m_ready) m_writes++;
      m_level = m_writes - rd_d2;
      m_full  = (m_level == DEPTH);
      m_ready = !m_full;
      m_afull = (m_level >= 3);
      rd_d2   = rd_d1;
      rd_d1   = m_reads;
    end
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wvalid = 1'b0;
    @(posedge wclk); #3;
    wrst = 1'b1;
    m_reads = 0;
    #12;
    @(negedge wclk);
    wrst = 1'b0;
    @(posedge wclk); #1;
  endtask

  task automatic test_reset();
    wrst = 1'b1; wvalid = 1'b1; m_reads = 0;
    #12;
    n_vec++; if (wready !== 1'b0) begin n_err++; $display("FAIL reset_wready: got %0d expected 0", wready); end
    n_vec++; if (wen !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %0d expected 0", wen); end
    n_vec++; if (wfull !== 1'b0 || walmost_full !== 1'b0) begin n_err++; $display("FAIL reset_flags: got full=%0d afull=%0d expected 0", wfull, walmost_full); end
    n_vec++; if (wlevel !== 3'd0 || waddr !== 2'd0 || wptr_gray !== 3'd0) begin n_err++; $display("FAIL reset_ptrs: got level=%0d addr=%0d gray=%0d expected 0", wlevel, waddr, wptr_gray); end
    @(negedge wclk);
    wrst = 1'b0;
    #1;
    n_vec++; if (wen !== 1'b0) begin n_err++; $display("FAIL release_wen: got %0d expected 0", wen); end
    tick();
    n_vec++; if (wready !== 1'b1) begin n_err++; $display("FAIL release_wready: got %0d expected 1", wready); end
  endtask

  task automatic test_fill();
    bit exp_wen;
    wvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_wen = m_ready;
      n_vec++; if (wen !== exp_wen) begin n_err++; $display("FAIL fill_wen: got %0d expected %0d", wen, exp_wen); end
      if (exp_wen) begin
        n_vec++; if (waddr !== 2'(m_writes)) begin n_err++; $display("FAIL fill_waddr: got %0d expected %0d", waddr, 2'(m_writes)); end
      end
      tick();
      n_vec++; if (wfull !== m_full || wready !== m_ready) begin n_err++; $display("FAIL fill_full: got full=%0d ready=%0d expected %0d %0d", wfull, wready, m_full, m_ready); end
      n_vec++; if (wlevel !== 3'(m_level) || walmost_full !== m_afull) begin n_err++; $display("FAIL fill_level: got %0d/%0d expected %0d/%0d", wlevel, walmost_full, m_level, m_afull); end
      n_vec++; if (wptr_gray !== gray3(m_writes)) begin n_err++; $display("FAIL fill_gray: got %b expected %b", wptr_gray, gray3(m_writes)); end
      if (m_writes == 3) begin
        n_vec++; if (walmost_full !== 1'b1) begin n_err++; $display("FAIL fill_afull3: got %0d expected 1", walmost_full); end
      end
    end
    n_vec++; if (wfull !== 1'b1 || wready !== 1'b0) begin n_err++; $display("FAIL fill_end_full: got full=%0d ready=%0d expected 1 0", wfull, wready); end
    n_vec++; if (wlevel !== 3'd4 || wptr_gray !== 3'b110) begin n_err++; $display("FAIL fill_end_ptr: got level=%0d gray=%b expected 4 110", wlevel, wptr_gray); end
    n_vec++; if (wen !== 1'b0) begin n_err++; $display("FAIL fill_end_wen: got %0d expected 0", wen); end
  endtask

  task automatic test_release();
    m_reads = 1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e < 3) begin
        n_vec++; if (wfull !== 1'b1 || wready !== 1'b0) begin n_err++; $display("FAIL release_inflight: got full=%0d ready=%0d expected 1 0", wfull, wready); end
      end
    end
    n_vec++; if (wfull !== 1'b0 || wready !== 1'b1) begin n_err++; $display("FAIL release_full: got full=%0d ready=%0d expected 0 1", wfull, wready); end
    n_vec++; if (wlevel !== 3'd3 || walmost_full !== 1'b1) begin n_err++; $display("FAIL release_level: got %0d/%0d expected 3/1", wlevel, walmost_full); end
    #1;
    n_vec++; if (wen !== 1'b1 || waddr !== 2'd0) begin n_err++; $display("FAIL release_next: got wen=%0d addr=%0d expected 1 0", wen, waddr); end
    tick();
    n_vec++; if (wfull !== m_full || wlevel !== 3'(m_level)) begin n_err++; $display("FAIL release_after: got %0d/%0d expected %0d/%0d", wfull, wlevel, m_full, m_level); end
  endtask

  task automatic test_wrap();
    int hist[$];
    int start_w;
    int cyc;
    bit exp_wen;
    logic [2:0] prev_g;
    start_w = m_writes;
    cyc = 0;
    while (m_writes - start_w < 12 && cyc < 300) begin
      wvalid = 1'($urandom_range(0, 3) != 0);
      #1;
      exp_wen = wvalid && m_ready;
      prev_g = wptr_gray;
      n_vec++; if (wen !== exp_wen) begin n_err++; $display("FAIL wrap_wen: got %0d expected %0d", wen, exp_wen); end
      if (exp_wen) begin
        n_vec++; if (waddr !== 2'(m_writes)) begin n_err++; $display("FAIL wrap_waddr: got %0d expected %0d", waddr, 2'(m_writes)); end
      end
      tick();
      n_vec++; if (wptr_gray !== gray3(m_writes)) begin n_err++; $display("FAIL wrap_gray: got %b expected %b", wptr_gray, gray3(m_writes)); end
      n_vec++; if ($countones(wptr_gray ^ prev_g) !== (exp_wen ? 1 : 0)) begin n_err++; $display("FAIL wrap_gray_step: got %b->%b expected %0d bit change", prev_g, wptr_gray, exp_wen); end
      n_vec++; if (wfull !== m_full || wready !== m_ready) begin n_err++; $display("FAIL wrap_full: got %0d/%0d expected %0d/%0d", wfull, wready, m_full, m_ready); end
      n_vec++; if (wlevel !== 3'(m_level) || walmost_full !== m_afull) begin n_err++; $display("FAIL wrap_level: got %0d/%0d expected %0d/%0d", wlevel, walmost_full, m_level, m_afull); end
      hist.push_back(m_writes);
      if (hist.size() > 3) m_reads = hist.pop_front();
      cyc++;
    end
    n_vec++; if (m_writes - start_w < 12) begin n_err++; $display("FAIL wrap_timeout: got %0d writes expected 12", m_writes - start_w); end
  endtask

  task automatic test_idle_gaps();
    bit exp_wen;
    int lvl_before;
    wvalid = 1'b0;
    m_reads = m_writes;
    repeat (4) tick();
    for (int c = 0; c < 8; c++) begin
      wvalid = ((c % 2) == 0);
      #1;
      exp_wen = wvalid && m_ready;
      lvl_before = int'(wlevel);
      n_vec++; if (wen !== exp_wen) begin n_err++; $display("FAIL gap_wen: got %0d expected %0d", wen, exp_wen); end
      if (exp_wen) begin
        n_vec++; if (waddr !== 2'(m_writes)) begin n_err++; $display("FAIL gap_waddr: got %0d expected %0d", waddr, 2'(m_writes)); end
      end
      tick();
      n_vec++; if (int'(wlevel) !== lvl_before + (exp_wen ? 1 : 0) || wlevel !== 3'(m_level)) begin n_err++; $display("FAIL gap_level: got %0d expected %0d", wlevel, m_level); end
      n_vec++; if (wptr_gray !== gray3(m_writes) || wfull !== m_full) begin n_err++; $display("FAIL gap_state: got gray=%b full=%0d expected %b %0d", wptr_gray, wfull, gray3(m_writes), m_full); end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    wvalid = 1'b1;
    while (m_writes < 2) tick();
    wvalid = 1'b0;
    tick();
    n_vec++; if (wlevel !== 3'd2 || wfull !== 1'b0) begin n_err++; $display("FAIL midop_pre: got level=%0d full=%0d expected 2 0", wlevel, wfull); end
    #2;
    wrst = 1'b1;
    m_reads = 0;
    #1;
    n_vec++; if (wready !== 1'b0 || wen !== 1'b0 || wfull !== 1'b0 || walmost_full !== 1'b0) begin n_err++; $display("FAIL midop_flags: got rdy=%0d wen=%0d full=%0d af=%0d expected 0", wready, wen, wfull, walmost_full); end
    n_vec++; if (wlevel !== 3'd0 || waddr !== 2'd0 || wptr_gray !== 3'd0) begin n_err++; $display("FAIL midop_ptrs: got %0d/%0d/%b expected 0", wlevel, waddr, wptr_gray); end
    @(negedge wclk);
    wrst = 1'b0;
    tick();
    n_vec++; if (wready !== 1'b1 || waddr !== 2'd0 || wlevel !== 3'd0) begin n_err++; $display("FAIL midop_release: got rdy=%0d addr=%0d level=%0d expected 1 0 0", wready, waddr, wlevel); end
  endtask

  initial begin
    wrst = 1'b1;
    wvalid = 1'b0;
    test_reset();
    test_fill();
    test_release();
    test_wrap();
    test_idle_gaps();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
